// File: rtl/snn_pkg.sv
// Shared rate-code definitions: decoder state enum, default code timing
// constants used by both the encoder neuron and spike_decoder, and a vote helper.
package snn_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

   // Both ends of the spike line must agree on these.
   localparam int N_DEF       = 10;
   localparam int M_DEF       = 5;
   localparam int TIMEOUT_DEF = 20;
   localparam int CW_DEF      = 5;

   function automatic logic maj3(input logic [2:0] h);
      return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
   endfunction

endpackage

// File: rtl/isi_counter.sv
// Saturating inter-spike interval counter: load forces 1, otherwise counts up
// and sticks at TIMEOUT; sat flags that the ceiling has been reached.
module isi_counter #(
   parameter int CW      = 5,
   parameter int TIMEOUT = 20
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   output logic [CW-1:0] value,
   output logic          sat
);

   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

   assign sat = (value == TMAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
      end else if (load) begin
         value <= CW'(1);
      end else if (!sat) begin
         value <= value + CW'(1);
      end
   end

endmodule

// File: rtl/spike_decoder.sv
// Rate-code decoder: classifies inter-spike intervals as 1 (short) or 0 (long).
// Define SPIKE_DECODER_MAJORITY_EN to vote over the last three classifications.
//
// Handshake: none. spikeInput is a one-cycle strobe sampled every rising edge;
// decodedValue is meaningful only while valid=1; glitch/lockLost are one-cycle
// pulses that need no acknowledge.
module spike_decoder
   import snn_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int M       = M_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CW      = CW_DEF
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   spikeInput,
   output logic   decodedValue,
   output logic   valid,
   output logic   glitch,
   output logic   lockLost,
   output state_t state_dbg
);

   localparam logic [CW-1:0] THR  = CW'((M + N) / 2);
   localparam logic [CW-1:0] MINI = CW'(M - 1);

   state_t        state, state_n;
   logic          dec_n, valid_n, glitch_n, lost_n;
   logic [CW-1:0] isi;
   logic          sat;
   logic          cls;

`ifdef SPIKE_DECODER_MAJORITY_EN
   logic [2:0]    hist, hist_n;
   logic [1:0]    fill, fill_n;
`endif

   // Every spike, accepted or rejected, restarts the interval measurement.
   isi_counter #(.CW(CW), .TIMEOUT(TIMEOUT)) u_isi (
      .clk   (clk),
      .rst   (reset),
      .load  (spikeInput),
      .value (isi),
      .sat   (sat)
   );

   assign cls       = (isi <= THR);
   assign state_dbg = state;

   always_comb begin
      state_n  = state;
      dec_n    = decodedValue;
      valid_n  = valid;
      glitch_n = 1'b0;
      lost_n   = 1'b0;
`ifdef SPIKE_DECODER_MAJORITY_EN
      hist_n   = hist;
      fill_n   = fill;
`endif
      case (state)
         IDLE: begin
            if (spikeInput) state_n = MEASURE;
         end
         MEASURE: begin
            // A spike landing on the saturated count is still a valid long interval.
            if (spikeInput) begin
               if (isi < MINI) begin
                  glitch_n = 1'b1;
               end else begin
`ifdef SPIKE_DECODER_MAJORITY_EN
                  hist_n  = {hist[1:0], cls};
                  fill_n  = (fill == 2'd3) ? 2'd3 : fill + 2'd1;
                  dec_n   = maj3(hist_n);
                  valid_n = (fill_n == 2'd3);
`else
                  dec_n   = cls;
                  valid_n = 1'b1;
`endif
               end
            end else if (sat) begin
               state_n = IDLE;
               lost_n  = 1'b1;
               valid_n = 1'b0;
`ifdef SPIKE_DECODER_MAJORITY_EN
               hist_n  = '0;
               fill_n  = '0;
`endif
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         decodedValue <= 1'b0;
         valid        <= 1'b0;
         glitch       <= 1'b0;
         lockLost     <= 1'b0;
      end else begin
         state        <= state_n;
         decodedValue <= dec_n;
         valid        <= valid_n;
         glitch       <= glitch_n;
         lockLost     <= lost_n;
      end
   end

`ifdef SPIKE_DECODER_MAJORITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist <= '0;
         fill <= '0;
      end else begin
         hist <= hist_n;
         fill <= fill_n;
      end
   end
`endif

endmodule

// File: doc/spike_decoder.md
# spike_decoder

Rate-code decoder: recovers a 1-bit value from a spike train produced by the team's rate-coded encoder neuron by measuring inter-spike intervals (ISI). A short period (about M cycles) decodes as 1 and a long period (about N cycles) decodes as 0. It sits at the receiving end of the encoder's spike line, on the same clock, and feeds decoded bits to downstream readout or scoring logic.

## Interface
- N, default 10: nominal ISI for value 0 (cycles).
- M, default 5: nominal ISI for value 1 (cycles); requires M < N.
- TIMEOUT, default 20: ISI at which lock is declared lost; requires TIMEOUT > N.
- CW, default 5: interval-counter width; requires 2^CW − 1 ≥ TIMEOUT.
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- spikeInput, in, 1: spike line, synchronous to clk; one spike = one high cycle.
- decodedValue, out, 1: current decoded bit.
- valid, out, 1: decodedValue holds a classification from the current lock.
- glitch, out, 1: one-cycle pulse when a too-short interval is rejected.
- lockLost, out, 1: one-cycle pulse on timeout.

## Operation
- THR = (M+N)/2, integer division; 7 at defaults. MINI = M−1; 4 at defaults.
- The interval counter is set to 1 at every accepted or rejected spike, increments on every non-spike cycle, and saturates at TIMEOUT.
- On a spike, interval I equals the current counter value. Spikes at edges t and t+I give interval I.
- States:
  - IDLE: reset state. A spike moves to MEASURE with the counter set to 1. No classification occurs.
  - MEASURE: on a spike with I < MINI, pulse glitch, set the counter to 1, and keep state and outputs unchanged. On a spike with I ≥ MINI, classify: bit = 1 if I ≤ THR, else 0. Update decodedValue, set valid per the Configuration section, set the counter to 1, and stay in MEASURE.
  - Timeout: at an edge where spikeInput=0 and counter == TIMEOUT, go to IDLE, pulse lockLost, and clear valid. decodedValue holds its last value.
- A spike at the edge where counter == TIMEOUT is a normal interval (classifies as 0). The spike wins over the timeout.
- Reset values: decodedValue=0, valid=0, glitch=0, lockLost=0, state IDLE, counter 0, history 0.
- Asserting reset mid-operation forces reset values asynchronously. The first spike after release is treated as an IDLE spike.

## Timing
- spikeInput is sampled on the rising edge.
- All outputs are registered. The classification for the spike sampled at edge t appears on decodedValue and valid after edge t, with no additional latency.
- glitch and lockLost are high for exactly the cycle following their causing edge.
- At the encoder's jitter, ISI ∈ {M−1, M} decodes as 1 and ISI ∈ {N−1, N} decodes as 0.

## Configuration
- SPIKE_DECODER_MAJORITY_EN defined:
  - Keep a 3-entry shift history of classifications and a 2-bit fill count, both cleared on reset and on timeout.
  - decodedValue = majority of the 3 entries.
  - valid rises only once 3 classifications have occurred since the last IDLE→MEASURE transition.
  - Glitches do not shift the history.
- SPIKE_DECODER_MAJORITY_EN undefined:
  - decodedValue = latest classification.
  - valid rises at the first classification after IDLE→MEASURE.

## Structure
- Shared package (snn_pkg) holds:
  - the state enum (IDLE, MEASURE);
  - default constants for N, M, TIMEOUT and CW, shared with the encoder neuron so both ends agree on the code.
- One sub-module, isi_counter: a saturating CW-bit counter with a load-1 input, a saturate-at-TIMEOUT flag, and a value output.
- Classification, history and the FSM live in spike_decoder.

## Test plan
- Spikes every 5 cycles, 4 spikes, macro off → valid=1 and decodedValue=1 after the 2nd spike. glitch and lockLost stay 0.
- Spikes every 10 cycles → decodedValue=0 after the 2nd spike. Intervals alternating 4/9 → decodedValue toggles 1,0,1.
- One spike, then idle → after 20 cycles, lockLost pulses for 1 cycle, valid=0, and decodedValue is retained. The next spike re-enters MEASURE with no classification.
- Intervals 5, 2, 5 → glitch pulses after the interval-2 spike with decodedValue unchanged. The next interval is measured from the glitch spike, so the final 5 still decodes as 1.
- Spike at exactly counter==20 → decodes as 0 with no lockLost. Reset asserted mid-interval → all outputs 0 immediately, without waiting for a clock edge.
- Macro on, intervals 5,10,5 → valid rises after the 4th spike with decodedValue=1. A further interval of 10 gives history 0,1,0 → decodedValue=0.
